// File: rtl/gps_uart_pkg.sv
// gps_uart_pkg: shared types and constants for the GPS-receiver UART transmitter.
//   tx_state_e         transmitter FSM states
//   SPEED_SLOW/FAST    encodings of tx_req_speed / tx_cur_speed
//   DEF_*              default divisors (50 MHz at 9600 / 115200 baud) and guard length
//   FRAME_BITS         bits per 8N1 frame (start + 8 data + stop)
//   cnt_width()        counter width able to count 0..max_val-1
package gps_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_SWITCH
    } tx_state_e;

    localparam logic SPEED_SLOW = 1'b0;
    localparam logic SPEED_FAST = 1'b1;

    localparam int unsigned DEF_CLKS_PER_BIT_SLOW = 5208;
    localparam int unsigned DEF_CLKS_PER_BIT_FAST = 434;
    localparam int unsigned DEF_GUARD_BITS        = 2;
    localparam int unsigned FRAME_BITS            = 10;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/gps_uart_tx_if.sv
// gps_uart_tx_if: controller <-> transmitter signal bundle.
//   tx_data[7:0]   byte to send (sampled on the accept cycle)
//   tx_send        single-cycle send strobe
//   tx_busy        frame or rate switch in progress
//   tx_req_speed   requested rate (0 = slow, 1 = fast)
//   tx_cur_speed   rate currently in effect
//   tx             serial line to the GPS RX pin, idle high
//   tx_byte_count  accepted-byte counter (only with GPS_TX_STATS_EN defined)
// Modports: master = GPS controller, slave = transmitter.
interface gps_uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       tx_req_speed;
    logic       tx_cur_speed;
    logic       tx;
`ifdef GPS_TX_STATS_EN
    logic [15:0] tx_byte_count;

    modport master (
        output tx_data, tx_send, tx_req_speed,
        input  tx_busy, tx_cur_speed, tx, tx_byte_count
    );

    modport slave (
        input  tx_data, tx_send, tx_req_speed,
        output tx_busy, tx_cur_speed, tx, tx_byte_count
    );
`else
    modport master (
        output tx_data, tx_send, tx_req_speed,
        input  tx_busy, tx_cur_speed, tx
    );

    modport slave (
        input  tx_data, tx_send, tx_req_speed,
        output tx_busy, tx_cur_speed, tx
    );
`endif

endinterface

// File: rtl/gps_uart_tx_baud_gen.sv
// gps_baud_gen: bit-time tick generator.
//   clk, rst      clock, asynchronous active-low reset
//   restart       synchronous: hold the counter at 0
//   divisor[CW]   clk cycles per bit
//   tick          high on the last cycle of each bit time (count == divisor-1)
module gps_baud_gen #(
    parameter int unsigned CW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic [CW-1:0] divisor,
    output logic          tick
);

    logic [CW-1:0] cnt;

    assign tick = (cnt == divisor - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gps_uart_tx.sv
// gps_uart_tx: 8N1, LSB-first serial transmitter for the GPS receiver RX pin,
// with a slow (power-on) and fast (post-config) baud rate.
//   clk            system clock
//   rst            asynchronous, active-low reset
//   bus            gps_uart_tx_if.slave (tx_data, tx_send, tx_busy,
//                  tx_req_speed, tx_cur_speed, tx[, tx_byte_count])
// Optional: define GPS_TX_STATS_EN to add the 16-bit wrapping tx_byte_count.
// A rate change is only taken in IDLE and holds the line idle for
// GUARD_BITS bit times at the old rate before the new rate applies.
module gps_uart_tx
    import gps_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT_SLOW = DEF_CLKS_PER_BIT_SLOW,
    parameter int unsigned CLKS_PER_BIT_FAST = DEF_CLKS_PER_BIT_FAST,
    parameter int unsigned GUARD_BITS        = DEF_GUARD_BITS
) (
    input logic          clk,
    input logic          rst,
    gps_uart_tx_if.slave bus
);

    localparam int unsigned MAX_DIV = (CLKS_PER_BIT_SLOW > CLKS_PER_BIT_FAST) ?
                                      CLKS_PER_BIT_SLOW : CLKS_PER_BIT_FAST;
    localparam int unsigned CW        = cnt_width(MAX_DIV);
    localparam int unsigned GW        = cnt_width(GUARD_BITS);
    localparam int unsigned DATA_BITS = FRAME_BITS - 2;
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_e     state_q, state_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          cur_q, cur_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [GW-1:0] guard_q, guard_d;
`ifdef GPS_TX_STATS_EN
    logic [15:0]   cnt_q, cnt_d;
`endif

    logic [CW-1:0] divisor;
    logic          tick;

    // Divisor only follows cur_q, which cannot change mid-frame.
    assign divisor = (cur_q == SPEED_FAST) ? CW'(CLKS_PER_BIT_FAST) : CW'(CLKS_PER_BIT_SLOW);

    gps_baud_gen #(
        .CW (CW)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == ST_IDLE),
        .divisor (divisor),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            cur_q     <= SPEED_SLOW;
            shift_q   <= '0;
            bit_idx_q <= '0;
            guard_q   <= '0;
`ifdef GPS_TX_STATS_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            cur_q     <= cur_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            guard_q   <= guard_d;
`ifdef GPS_TX_STATS_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        cur_d     = cur_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        guard_d   = guard_q;
`ifdef GPS_TX_STATS_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Rate change wins over a simultaneous send; the byte is dropped.
                if (bus.tx_req_speed != cur_q) begin
                    state_d = ST_SWITCH;
                    busy_d  = 1'b1;
                    guard_d = '0;
                end else if (bus.tx_send) begin
                    state_d = ST_START;
                    shift_d = bus.tx_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef GPS_TX_STATS_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_SWITCH: begin
                if (tick) begin
                    if (guard_q == GW'(GUARD_BITS - 1)) begin
                        // Always lands on the rate requested at entry (the
                        // opposite of cur_q); a reverted request is then
                        // picked up by IDLE as a fresh switch.
                        cur_d   = ~cur_q;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        guard_d = guard_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_cur_speed = cur_q;
`ifdef GPS_TX_STATS_EN
    assign bus.tx_byte_count = cnt_q;
`endif

endmodule

// File: tb/tb_gps_uart_tx.sv
module tb_gps_uart_tx;

    localparam int unsigned SLOW  = 16;
    localparam int unsigned FAST  = 4;
    localparam int unsigned GUARD = 2;

    typedef struct {
        logic [7:0]  data;
        int unsigned div;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gps_uart_tx_if bus ();

    gps_uart_tx #(
        .CLKS_PER_BIT_SLOW (SLOW),
        .CLKS_PER_BIT_FAST (FAST),
        .GUARD_BITS        (GUARD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          passed = 0;
    exp_t        sb[$];
    logic        mon_en = 1'b0;
    int unsigned model_div = SLOW;
`ifdef GPS_TX_STATS_EN
    logic [15:0] model_count = '0;
`endif

    // Frame monitor: samples each bit in the middle of its bit time and
    // compares against the byte queued when the send was driven.
    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        logic       s0, s9;
        forever begin
            @(negedge clk);
            if (mon_en && bus.tx === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got start bit, expected idle line");
                    repeat (10 * model_div) @(negedge clk);
                end else begin
                    e = sb[0];
                    repeat (e.div / 2) @(negedge clk);
                    s0 = bus.tx;
                    for (int k = 0; k < 8; k++) begin
                        repeat (e.div) @(negedge clk);
                        got[k] = bus.tx;
                    end
                    repeat (e.div) @(negedge clk);
                    s9 = bus.tx;
                    void'(sb.pop_front());
                    checks++; if (s0 !== 1'b0) $display("FAIL frame_start: got %b expected 0", s0); else passed++;
                    checks++; if (got !== e.data) $display("FAIL frame_data: got %02h expected %02h", got, e.data); else passed++;
                    checks++; if (s9 !== 1'b1) $display("FAIL frame_stop: got %b expected 1", s9); else passed++;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got still running, expected completion");
        $fatal(1, "timeout");
    end

    // Caller is away from the rising edge; returns #1 after the accept edge.
    task automatic send_byte(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_send = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_send = 1'b0;
    endtask

    // Counts clk cycles with tx_busy high; returns at the first negedge with it low.
    task automatic measure_busy(output int unsigned n, output logic saw_low);
        n = 0;
        saw_low = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (bus.tx_busy !== 1'b1) break;
            n++;
            if (bus.tx === 1'b0) saw_low = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", bus.tx); else passed++;
        checks++; if (bus.tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.tx_busy); else passed++;
        checks++; if (bus.tx_cur_speed !== 1'b0) $display("FAIL reset_speed: got %b expected 0", bus.tx_cur_speed); else passed++;
`ifdef GPS_TX_STATS_EN
        checks++; if (bus.tx_byte_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", bus.tx_byte_count); else passed++;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_slow_send();
        int unsigned n;
        logic        lo;
        sb.push_back('{8'hB5, SLOW});
        send_byte(8'hB5);
        checks++; if (bus.tx !== 1'b0) $display("FAIL slow_latency_tx: got %b expected 0", bus.tx); else passed++;
        checks++; if (bus.tx_busy !== 1'b1) $display("FAIL slow_latency_busy: got %b expected 1", bus.tx_busy); else passed++;
        measure_busy(n, lo);
        checks++; if (n !== 10 * SLOW) $display("FAIL slow_busy_len: got %0d expected %0d", n, 10 * SLOW); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL slow_sb_empty: got %0d pending expected 0", sb.size()); else passed++;
    endtask

    task automatic test_rate_switch();
        int unsigned n;
        logic        lo;
        bus.tx_req_speed = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.tx_busy !== 1'b1) $display("FAIL switch_busy: got %b expected 1", bus.tx_busy); else passed++;
        measure_busy(n, lo);
        checks++; if (n !== GUARD * SLOW) $display("FAIL switch_up_len: got %0d expected %0d", n, GUARD * SLOW); else passed++;
        checks++; if (lo !== 1'b0) $display("FAIL switch_line_idle: got low %b expected 0", lo); else passed++;
        checks++; if (bus.tx_cur_speed !== 1'b1) $display("FAIL switch_up_speed: got %b expected 1", bus.tx_cur_speed); else passed++;
        model_div = FAST;
        sb.push_back('{8'h62, FAST});
        send_byte(8'h62);
        measure_busy(n, lo);
        checks++; if (n !== 10 * FAST) $display("FAIL fast_busy_len: got %0d expected %0d", n, 10 * FAST); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL fast_sb_empty: got %0d pending expected 0", sb.size()); else passed++;
        bus.tx_req_speed = 1'b0;
        @(posedge clk);
        #1;
        measure_busy(n, lo);
        checks++; if (n !== GUARD * FAST) $display("FAIL switch_down_len: got %0d expected %0d", n, GUARD * FAST); else passed++;
        checks++; if (bus.tx_cur_speed !== 1'b0) $display("FAIL switch_down_speed: got %b expected 0", bus.tx_cur_speed); else passed++;
        model_div = SLOW;
    endtask

    task automatic test_busy_drop();
        int unsigned n;
        sb.push_back('{8'h11, SLOW});
        send_byte(8'h11);
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (bus.tx_busy !== 1'b1) break;
            n++;
            bus.tx_send = (n == 50);
            bus.tx_data = (n == 50) ? 8'hFF : 8'h11;
        end
        bus.tx_send = 1'b0;
        checks++; if (n !== 10 * SLOW) $display("FAIL drop_busy_len: got %0d expected %0d", n, 10 * SLOW); else passed++;
        repeat (200) @(negedge clk);
        checks++; if (sb.size() !== 0) $display("FAIL drop_sb_empty: got %0d pending expected 0", sb.size()); else passed++;
        checks++; if (bus.tx_busy !== 1'b0) $display("FAIL drop_idle_busy: got %b expected 0", bus.tx_busy); else passed++;
    endtask

    task automatic test_collision();
        int unsigned n;
        logic        lo;
        bus.tx_data      = 8'hAA;
        bus.tx_send      = 1'b1;
        bus.tx_req_speed = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_send = 1'b0;
        checks++; if (bus.tx !== 1'b1) $display("FAIL coll_no_start: got %b expected 1", bus.tx); else passed++;
        measure_busy(n, lo);
        checks++; if (n !== GUARD * SLOW) $display("FAIL coll_guard_len: got %0d expected %0d", n, GUARD * SLOW); else passed++;
        checks++; if (lo !== 1'b0) $display("FAIL coll_line_idle: got low %b expected 0", lo); else passed++;
        checks++; if (bus.tx_cur_speed !== 1'b1) $display("FAIL coll_speed: got %b expected 1", bus.tx_cur_speed); else passed++;
        bus.tx_req_speed = 1'b0;
        @(posedge clk);
        #1;
        measure_busy(n, lo);
        checks++; if (bus.tx_cur_speed !== 1'b0) $display("FAIL coll_restore: got %b expected 0", bus.tx_cur_speed); else passed++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int unsigned n;
        logic        lo;
        sb.push_back('{8'hC3, SLOW});
        sb.push_back('{8'h5A, SLOW});
        send_byte(8'hC3);
        measure_busy(n, lo);
        checks++; if (n !== 10 * SLOW) $display("FAIL b2b_first_len: got %0d expected %0d", n, 10 * SLOW); else passed++;
        checks++; if (bus.tx !== 1'b1) $display("FAIL b2b_gap: got %b expected 1", bus.tx); else passed++;
        send_byte(8'h5A);
        checks++; if (bus.tx !== 1'b0) $display("FAIL b2b_second_start: got %b expected 0", bus.tx); else passed++;
        measure_busy(n, lo);
        checks++; if (n !== 10 * SLOW) $display("FAIL b2b_second_len: got %0d expected %0d", n, 10 * SLOW); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (sb.size() !== 0) $display("FAIL b2b_sb_empty: got %0d pending expected 0", sb.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        int unsigned n;
        logic        lo;
        bus.tx_req_speed = 1'b1;
        @(posedge clk);
        #1;
        measure_busy(n, lo);
        checks++; if (bus.tx_cur_speed !== 1'b1) $display("FAIL rmid_pre_speed: got %b expected 1", bus.tx_cur_speed); else passed++;
        mon_en = 1'b0;
        send_byte(8'h0F);
        // Bit 4 occupies cycles 20..23 after the accept edge at the fast rate.
        repeat (22) @(negedge clk);
        checks++; if (bus.tx !== 1'b0) $display("FAIL rmid_bit4: got %b expected 0", bus.tx); else passed++;
        #2;
        rst = 1'b0;
        bus.tx_req_speed = 1'b0;
        #1;
        checks++; if (bus.tx !== 1'b1) $display("FAIL rmid_tx: got %b expected 1", bus.tx); else passed++;
        checks++; if (bus.tx_busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", bus.tx_busy); else passed++;
        checks++; if (bus.tx_cur_speed !== 1'b0) $display("FAIL rmid_speed: got %b expected 0", bus.tx_cur_speed); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.tx_busy !== 1'b0) $display("FAIL rmid_no_resume: got %b expected 0", bus.tx_busy); else passed++;
`ifdef GPS_TX_STATS_EN
        model_count = '0;
`endif
        model_div = SLOW;
        mon_en = 1'b1;
        sb.push_back('{8'h3C, SLOW});
        send_byte(8'h3C);
`ifdef GPS_TX_STATS_EN
        model_count = model_count + 16'd1;
`endif
        measure_busy(n, lo);
        checks++; if (n !== 10 * SLOW) $display("FAIL rmid_clean_len: got %0d expected %0d", n, 10 * SLOW); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL rmid_sb_empty: got %0d pending expected 0", sb.size()); else passed++;
    endtask

    task automatic test_stats();
`ifdef GPS_TX_STATS_EN
        int unsigned n;
        logic        lo;
        for (int b = 0; b < 3; b++) begin
            sb.push_back('{8'h40 + 8'(b), SLOW});
            send_byte(8'h40 + 8'(b));
            model_count = model_count + 16'd1;
            if (b == 1) begin
                repeat (30) @(negedge clk);
                send_byte(8'hEE);
            end
            measure_busy(n, lo);
        end
        checks++; if (bus.tx_byte_count !== model_count) $display("FAIL stats_count: got %0d expected %0d", bus.tx_byte_count, model_count); else passed++;
        bus.tx_req_speed = 1'b1;
        @(posedge clk);
        #1;
        measure_busy(n, lo);
        bus.tx_req_speed = 1'b0;
        @(posedge clk);
        #1;
        measure_busy(n, lo);
        checks++; if (bus.tx_byte_count !== model_count) $display("FAIL stats_switch: got %0d expected %0d", bus.tx_byte_count, model_count); else passed++;
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        checks++; if (bus.tx_byte_count !== 16'hFFFF) $display("FAIL stats_preload: got %0h expected ffff", bus.tx_byte_count); else passed++;
        sb.push_back('{8'h99, SLOW});
        send_byte(8'h99);
        checks++; if (bus.tx_byte_count !== 16'h0000) $display("FAIL stats_wrap: got %0h expected 0", bus.tx_byte_count); else passed++;
        measure_busy(n, lo);
`endif
    endtask

    initial begin : main
        bus.tx_data      = '0;
        bus.tx_send      = 1'b0;
        bus.tx_req_speed = 1'b0;
        test_reset();
        @(negedge clk);
        test_slow_send();
        test_rate_switch();
        test_busy_drop();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        repeat (20) @(negedge clk);
        checks++; if (sb.size() !== 0) $display("FAIL final_sb_empty: got %0d pending expected 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gps_uart_tx.md
Name: gps_uart_tx

Overview:
- Serial transmitter feeding the GPS receiver's RX pin.
- Accepts configuration bytes from the GPS controller (tx_data/tx_send) and serialises them as 8N1, LSB first.
- Supports two baud rates (power-on slow rate, post-config fast rate); switches only on an idle line and reports the active rate on tx_cur_speed.

Parameters:
- CLKS_PER_BIT_SLOW, 5208, clk cycles per bit at slow rate (50 MHz / 9600).
- CLKS_PER_BIT_FAST, 434, clk cycles per bit at fast rate (50 MHz / 115200).
- GUARD_BITS, 2, idle bit-times held at the old rate before a rate change takes effect.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tx_data  in  8  byte to send; sampled only on the accept cycle
- tx_send  in  1  single-cycle send strobe
- tx_busy  out  1  high while a frame or rate switch is in progress
- tx_req_speed  in  1  requested rate: 0 = slow, 1 = fast
- tx_cur_speed  out  1  rate currently in effect
- tx  out  1  serial line, idle high

Behaviour:
- Reset (rst low, async) sets: tx=1, tx_busy=0, tx_cur_speed=0, state=IDLE, all counters=0. Deasserting mid-frame leaves the line high; no partial frame resumes.
- States: IDLE, START, DATA, STOP, SWITCH. All outputs are registered.
- Divisor = tx_cur_speed ? CLKS_PER_BIT_FAST : CLKS_PER_BIT_SLOW. The divisor is fixed for the whole frame.
- Bit tick: divider counter counts 0..divisor-1. The tick fires at divisor-1, then the counter returns to 0. Counter width = clog2(max divisor).
- IDLE, priority order:
  - (1) tx_req_speed != tx_cur_speed: go to SWITCH, tx_busy=1; a simultaneous tx_send is dropped.
  - (2) else tx_send=1: latch tx_data into the shift register, go to START; tx=0 and tx_busy=1 on the next edge. Accept-to-start-bit latency is 1 clk.
- START: hold tx=0 for 1 bit-time, then go to DATA with bit index 0.
- DATA: drive shift[0] each bit-time and shift right. After bit index 7 completes, go to STOP.
- STOP: tx=1 for 1 bit-time. At the stop-bit tick, go to IDLE and set tx_busy=0 on the same edge. Back-to-back frames are therefore separated by at least 1 clk of idle.
- SWITCH: tx=1 for GUARD_BITS bit-times at the old divisor. On the final tick, tx_cur_speed<=tx_req_speed, go to IDLE, tx_busy=0.
  - If tx_req_speed reverts during SWITCH, the switch still completes, and IDLE then schedules another switch.
- tx_send while tx_busy=1 is ignored, with no queueing.
- Frame length = 10 × divisor clk; tx_busy is high for exactly 10 × divisor cycles per byte.
- Controller contract: assert tx_send only when tx_busy=0 and tx_req_speed==tx_cur_speed.

Optional Feature:
- Macro: GPS_TX_STATS_EN.
- Defined: adds output tx_byte_count[15:0].
  - Reset to 0.
  - Increments on each accepted byte (accept edge) and wraps 0xFFFF→0.
  - Unchanged by rate switches and dropped sends.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gps_uart_pkg:
  - tx state enum (IDLE/START/DATA/STOP/SWITCH);
  - SPEED_SLOW=0 / SPEED_FAST=1 constants;
  - default divisors 5208 and 434;
  - FRAME_BITS=10.
- Sub-module gps_baud_gen: divisor-selectable tick counter with a synchronous restart input, instantiated once.

Test Plan:
- Slow send: CLKS_PER_BIT_SLOW=16, send 0xB5 → tx pattern start 0, bits 1,0,1,0,1,1,0,1, stop 1; each bit 16 clk; tx_busy high 160 clk.
- Rate switch: CLKS_PER_BIT_FAST=4, GUARD_BITS=2, raise tx_req_speed in IDLE → tx_busy high 32 clk, tx_cur_speed=1 after; then send 0x62 → each bit 4 clk, tx_busy 40 clk.
- Busy drop: send 0x11, pulse tx_send with 0xFF mid-frame → only 0x11 appears on tx; tx_busy deasserts after 160 clk.
- Collision: tx_send=1 with 0xAA on the same cycle tx_req_speed changes → SWITCH entered, no start bit, byte dropped; tx_cur_speed updates after the guard.
- Reset mid-DATA: drive rst low at bit 4 → tx=1, tx_busy=0, tx_cur_speed=0 asynchronously; next send after release is a clean slow frame.
- GPS_TX_STATS_EN: send 3 bytes plus 1 dropped → tx_byte_count=3; preload via 65535 sends, or force the count to 0xFFFF → next accept reads 0.
